traffic_phase_scheduler: RTL

- Timed phase controller for a two-street intersection (street A, street B).
- Supersedes the purely sensor-driven light FSM with cycle-counted minimum/maximum green, yellow and all-red clearance intervals, plus a pedestrian walk phase requested through a pulse/acknowledge handshake.
- Drives the L_A/L_B lamp codes directly and sits between the sensor/button inputs and the lamp drivers.

---
 rtl/traffic_phase_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Timed two-street intersection controller. Green phases run for at least
// MIN_GREEN and at most MAX_GREEN clocks, followed by yellow and all-red
// clearance. A pedestrian walk phase is inserted at the next all-red after a
// request. Lamp, walk and ack outputs are registered, decoded from the
// next state so they line up with the state register.

module traffic_phase_scheduler #(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 12,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       T_A,
    input  logic       T_B,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic [1:0] L_A,
    output logic [1:0] L_B,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GREEN   = 3'd0,
        A_YELLOW  = 3'd1,
        ALLRED_AB = 3'd2,
        B_GREEN   = 3'd3,
        B_YELLOW  = 3'd4,
        ALLRED_BA = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    // Last counter value of each dwell: a dwell of N clocks ends at cnt == N-1.
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    // next_dir encoding: 1'b0 = street A, 1'b1 = street B
    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ped_pending_r;
    logic             ped_pending_nxt_s;
    logic             next_dir_r;
    logic             next_dir_nxt_s;
    logic             enter_walk_s;
    logic [1:0]       l_a_r;
    logic [1:0]       l_b_r;
    logic [1:0]       l_a_nxt_s;
    logic [1:0]       l_b_nxt_s;
    logic             walk_r;
    logic             walk_nxt_s;
    logic             ped_ack_r;
    logic             ped_ack_nxt_s;

    // Lamp code for one street given its own green and yellow states.
    function automatic logic [1:0] lamp_code(input state_t st,
                                             input state_t green_st,
                                             input state_t yellow_st);
        logic [1:0] code;
        if (st == green_st) begin
            code = LAMP_GREEN;
        end else if (st == yellow_st) begin
            code = LAMP_YELLOW;
        end else begin
            code = LAMP_RED;
        end
        return code;
    endfunction

    // Next-state, dwell counter, pedestrian bookkeeping and output decode.
    always_comb begin
        state_nxt_s    = state_r;
        next_dir_nxt_s = next_dir_r;

        case (state_r)
            A_GREEN: begin
                if ((cnt_r >= MIN_LAST) && (!T_A || (cnt_r >= MAX_LAST))) begin
                    state_nxt_s = A_YELLOW;
                end else begin
                    state_nxt_s = A_GREEN;
                end
            end
            A_YELLOW: begin
                if (cnt_r == YELLOW_LAST) begin
                    state_nxt_s = ALLRED_AB;
                end else begin
                    state_nxt_s = A_YELLOW;
                end
            end
            ALLRED_AB: begin
                if (cnt_r == ALLRED_LAST) begin
                    if (ped_pending_r) begin
                        state_nxt_s    = PED_WALK;
                        next_dir_nxt_s = DIR_B;
                    end else begin
                        state_nxt_s = B_GREEN;
                    end
                end else begin
                    state_nxt_s = ALLRED_AB;
                end
            end
            B_GREEN: begin
                if ((cnt_r >= MIN_LAST) && (!T_B || (cnt_r >= MAX_LAST))) begin
                    state_nxt_s = B_YELLOW;
                end else begin
                    state_nxt_s = B_GREEN;
                end
            end
            B_YELLOW: begin
                if (cnt_r == YELLOW_LAST) begin
                    state_nxt_s = ALLRED_BA;
                end else begin
                    state_nxt_s = B_YELLOW;
                end
            end
            ALLRED_BA: begin
                if (cnt_r == ALLRED_LAST) begin
                    if (ped_pending_r) begin
                        state_nxt_s    = PED_WALK;
                        next_dir_nxt_s = DIR_A;
                    end else begin
                        state_nxt_s = A_GREEN;
                    end
                end else begin
                    state_nxt_s = ALLRED_BA;
                end
            end
            PED_WALK: begin
                // Walk already runs all-red, so go straight to the next green.
                if (cnt_r == WALK_LAST) begin
                    if (next_dir_r == DIR_B) begin
                        state_nxt_s = B_GREEN;
                    end else begin
                        state_nxt_s = A_GREEN;
                    end
                end else begin
                    state_nxt_s = PED_WALK;
                end
            end
            default: begin
                // Illegal code 7 recovers to a known green.
                state_nxt_s = A_GREEN;
            end
        endcase

        // Counter restarts on every state change and saturates otherwise.
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // A request on the walk-entry clock survives and is served next time.
        enter_walk_s = (state_nxt_s == PED_WALK) && (state_r != PED_WALK);
        if (ped_req) begin
            ped_pending_nxt_s = 1'b1;
        end else if (enter_walk_s) begin
            ped_pending_nxt_s = 1'b0;
        end else begin
            ped_pending_nxt_s = ped_pending_r;
        end

        l_a_nxt_s     = lamp_code(state_nxt_s, A_GREEN, A_YELLOW);
        l_b_nxt_s     = lamp_code(state_nxt_s, B_GREEN, B_YELLOW);
        walk_nxt_s    = (state_nxt_s == PED_WALK);
        ped_ack_nxt_s = enter_walk_s;
    end

    // State, counter, pedestrian tracking and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= A_GREEN;
            cnt_r         <= CNT_ZERO;
            ped_pending_r <= 1'b0;
            next_dir_r    <= DIR_B;
            l_a_r         <= LAMP_GREEN;
            l_b_r         <= LAMP_RED;
            walk_r        <= 1'b0;
            ped_ack_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            ped_pending_r <= ped_pending_nxt_s;
            next_dir_r    <= next_dir_nxt_s;
            l_a_r         <= l_a_nxt_s;
            l_b_r         <= l_b_nxt_s;
            walk_r        <= walk_nxt_s;
            ped_ack_r     <= ped_ack_nxt_s;
        end
    end

    assign L_A     = l_a_r;
    assign L_B     = l_b_r;
    assign walk    = walk_r;
    assign ped_ack = ped_ack_r;
    assign phase   = state_r;

endmodule
